// File: rtl/cache_pkg.sv
// cache_pkg -- shared types and constants for the direct-mapped cache.
//   state_t   : controller FSM states (IDLE / REFILL / WRITE)
//   line_t    : one cache line (valid bit, tag, four data words)
//   OFFSET_W  : width of the word-offset field inside a line
//   addr_tag(): extracts the tag bits of a byte address for a given index width
package cache_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = 2;   // addr[3:2] selects the word in a line
    // Widest tag occurs at the smallest legal cache (2 lines -> 1 index bit).
    // Narrower tags are stored zero-extended into this field.
    localparam int TAG_MAX_W      = 32 - 4 - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    typedef struct packed {
        logic                                   valid;
        logic [TAG_MAX_W-1:0]                   tag;
        logic [WORDS_PER_LINE-1:0][WORD_W-1:0]  words;
    } line_t;

    // Tag = everything above the 4-bit line offset and the index field.
    function automatic logic [TAG_MAX_W-1:0] addr_tag(input logic [31:0] addr,
                                                       input int          idx_w);
        return TAG_MAX_W'(addr >> (4 + idx_w));
    endfunction

endpackage

// File: rtl/cache_array.sv
// cache_array -- LINES-entry tag/data store for the direct-mapped cache.
// Ports:
//   clk, reset          clock, asynchronous active-high reset (clears valid bits)
//   index               line selected for both read and update
//   rd_sel              word offset for the combinational read
//   rd_valid/rd_tag     valid bit and tag of the selected line
//   rd_word             selected word of the selected line
//   word_we/word_sel/wdata  single word-write port into the selected line
//   clr_valid           invalidate the selected line
//   set_valid/tag_in    mark the selected line valid and load its tag
module cache_array
    import cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     index,
    input  logic [OFFSET_W-1:0]  rd_sel,
    output logic                 rd_valid,
    output logic [TAG_MAX_W-1:0] rd_tag,
    output logic [WORD_W-1:0]    rd_word,
    input  logic                 word_we,
    input  logic [OFFSET_W-1:0]  word_sel,
    input  logic [WORD_W-1:0]    wdata,
    input  logic                 clr_valid,
    input  logic                 set_valid,
    input  logic [TAG_MAX_W-1:0] tag_in
);

    line_t lines [LINES];

    // Only the valid bits are reset; tags and data are don't-care while invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) lines[i].valid <= 1'b0;
        end else begin
            if (clr_valid) lines[index].valid <= 1'b0;
            if (set_valid) begin
                lines[index].valid <= 1'b1;
                lines[index].tag   <= tag_in;
            end
            if (word_we) lines[index].words[word_sel] <= wdata;
        end
    end

    assign rd_valid = lines[index].valid;
    assign rd_tag   = lines[index].tag;
    assign rd_word  = lines[index].words[rd_sel];

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl -- direct-mapped, write-through / no-allocate cache controller
// in front of an asynchronous SRAM.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request (held stable until done)
//   cpu_rdata                   read data, valid when the read completes
//   cpu_hold                    stall; request completes when cpu_hold=0
//   mem_addr/mem_data           SRAM address and bidirectional data bus
//   mem_ce_n/mem_we_n/mem_oe_n  SRAM strobes, active low
//   mem_bw                      SRAM word select, tied to 1
//   hit_cnt/miss_cnt            read hit / miss counters (CACHE_STATS_EN only)
// Optional feature: define CACHE_STATS_EN to add the hit/miss counters.
//
// Read hit: zero-wait. Read miss: 1 IDLE cycle + 4 REFILL cycles held, then
// the request hits. Write: 1 IDLE cycle held, then one WRITE cycle on the bus.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_hold,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    output logic        mem_ce_n,
    output logic        mem_we_n,
    output logic        mem_oe_n,
    output logic        mem_bw
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = $clog2(LINE_WORDS);

    state_t               state, next_state;
    logic [CNT_W-1:0]     cnt;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;

    // Outside IDLE the latched request address drives the lookup, so a CPU
    // that drops cpu_req mid-operation cannot disturb the refill or write.
    logic [31:0]          cur_addr;
    logic [IDX_W-1:0]     cur_index;
    logic [TAG_MAX_W-1:0] cur_tag;

    logic                 rd_valid;
    logic [TAG_MAX_W-1:0] rd_tag;
    logic [WORD_W-1:0]    rd_word;
    logic                 line_hit;

    logic                 hold_c;
    logic                 latch_req;
    logic                 word_we;
    logic [OFFSET_W-1:0]  word_sel;
    logic [WORD_W-1:0]    arr_wdata;
    logic                 clr_valid;
    logic                 set_valid;
    logic                 drive_bus;

    assign cur_addr  = (state == IDLE) ? cpu_addr : req_addr;
    assign cur_index = cur_addr[4 +: IDX_W];
    assign cur_tag   = addr_tag(cur_addr, IDX_W);
    assign line_hit  = rd_valid && (rd_tag == cur_tag);

    cache_array #(
        .LINES (LINES)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .index     (cur_index),
        .rd_sel    (cur_addr[3:2]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .word_we   (word_we),
        .word_sel  (word_sel),
        .wdata     (arr_wdata),
        .clr_valid (clr_valid),
        .set_valid (set_valid),
        .tag_in    (cur_tag)
    );

    // State, refill counter and request latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            state <= next_state;
            if (latch_req) begin
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
                cnt       <= '0;
            end else if (state == REFILL) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        hold_c     = 1'b0;
        latch_req  = 1'b0;
        mem_ce_n   = 1'b1;
        mem_we_n   = 1'b1;
        mem_oe_n   = 1'b1;
        mem_addr   = '0;
        drive_bus  = 1'b0;
        word_we    = 1'b0;
        word_sel   = cnt;
        arr_wdata  = mem_data;
        clr_valid  = 1'b0;
        set_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        hold_c     = 1'b1;
                        latch_req  = 1'b1;
                        next_state = WRITE;
                    end else if (!line_hit) begin
                        // Invalidate up front so an aborted refill leaves
                        // the line unusable.
                        hold_c     = 1'b1;
                        latch_req  = 1'b1;
                        clr_valid  = 1'b1;
                        next_state = REFILL;
                    end
                end
            end
            REFILL: begin
                hold_c    = 1'b1;
                mem_ce_n  = 1'b0;
                mem_oe_n  = 1'b0;
                mem_addr  = {req_addr[31:4], cnt, 2'b00};
                word_we   = 1'b1;
                word_sel  = cnt;
                arr_wdata = mem_data;
                if (cnt == CNT_W'(LINE_WORDS - 1)) begin
                    set_valid  = 1'b1;
                    next_state = IDLE;
                end
            end
            WRITE: begin
                mem_ce_n  = 1'b0;
                mem_we_n  = 1'b0;
                mem_addr  = req_addr;
                drive_bus = 1'b1;
                // Write-through, no-allocate: only refresh a resident copy.
                if (line_hit) begin
                    word_we   = 1'b1;
                    word_sel  = req_addr[3:2];
                    arr_wdata = req_wdata;
                end
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The FSM is already forced to IDLE by reset; the hold gate covers a
    // missing request presented while reset is still asserted.
    assign cpu_hold  = hold_c && !reset;
    assign cpu_rdata = rd_word;
    assign mem_bw    = 1'b1;
    assign mem_data  = drive_bus ? req_wdata : 32'bz;

`ifdef CACHE_STATS_EN
    // A hit right after a refill is the tail of that miss, not a new hit.
    logic after_refill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            after_refill <= 1'b0;
        end else begin
            after_refill <= (state == REFILL);
            if (state == IDLE && next_state == REFILL)
                miss_cnt <= miss_cnt + 32'd1;
            if (state == IDLE && cpu_req && !cpu_we && line_hit && !after_refill)
                hit_cnt <= hit_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl -- scoreboard bench for cache_ctrl with an SRAM model.
// The SRAM is preloaded with word i = 0xA5000000 | i starting at 0x10010000.
// Define CACHE_STATS_EN to also check hit_cnt / miss_cnt.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_hold;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    logic        mem_ce_n, mem_we_n, mem_oe_n, mem_bw;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    cache_ctrl #(.LINES(16), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_hold  (cpu_hold),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ce_n  (mem_ce_n),
        .mem_we_n  (mem_we_n),
        .mem_oe_n  (mem_oe_n),
        .mem_bw    (mem_bw)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write at the clock edge.
    logic        ram_load = 1'b1;
    logic [31:0] ram [256];
    assign mem_data = (!mem_ce_n && !mem_oe_n && mem_we_n) ? ram[mem_addr[9:2]] : 32'bz;
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | i;
        end else if (!mem_ce_n && !mem_we_n) begin
            ram[mem_addr[9:2]] <= mem_data;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard queues filled by the stimulus side.
    logic [31:0] rd_q [$];   // read data of completing reads
    logic [31:0] ra_q [$];   // refill bus addresses
    logic [63:0] wr_q [$];   // {addr, data} of write bus cycles

    // Monitor: compares whatever the DUT presents against the queue heads.
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_req && !cpu_hold && !cpu_we) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rd_unexpected: got %h, expected no read completion", cpu_rdata);
                end else chk("rdata", cpu_rdata, rd_q.pop_front());
            end
            if (!mem_ce_n && !mem_oe_n) begin
                if (ra_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL refill_unexpected: got %h, expected no refill cycle", mem_addr);
                end else chk("refill_addr", mem_addr, ra_q.pop_front());
            end
            if (!mem_ce_n && !mem_we_n) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL write_unexpected: got %h, expected no write cycle", mem_addr);
                end else begin
                    logic [63:0] w;
                    w = wr_q.pop_front();
                    chk("write_addr", mem_addr, w[63:32]);
                    chk("write_data", mem_data, w[31:0]);
                end
            end
        end
    end

    // Issue one access (called right after a rising edge) and wait for completion.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_hold, input logic refill);
        int  holds;
        bit  done;
        if (refill)
            for (int k = 0; k < 4; k++) ra_q.push_back({addr[31:4], k[1:0], 2'b00});
        if (we) wr_q.push_back({addr, wdata});
        else    rd_q.push_back(exp_rdata);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        holds = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (cpu_hold) holds++;
            else done = 1;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: addr %h still held after 20 cycles", addr);
        end
        chk("hold_cycles", holds, exp_hold);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a missing read presented to check hold gating.
        cpu_req = 1'b1; cpu_addr = 32'h1001_0000;
        repeat (2) @(posedge clk);
        #1;
        ram_load = 1'b0;
        chk("rst_hold", cpu_hold, 0);
        chk("rst_ce_n", mem_ce_n, 1);
        chk("rst_we_n", mem_we_n, 1);
        chk("rst_oe_n", mem_oe_n, 1);
        chk("rst_bw",   mem_bw, 1);
        chk("rst_addr", mem_addr, 32'h0);
`ifdef CACHE_STATS_EN
        chk("rst_hit_cnt",  hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
`endif
        cpu_req = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        access(0, 32'h1001_0000, 0, 32'hA500_0000, 5, 1);   // cold miss
        access(0, 32'h1001_0008, 0, 32'hA500_0002, 0, 0);   // zero-wait hit
        access(1, 32'h1001_0004, 32'hDEAD_BEEF, 0, 1, 0);   // write-through hit
        access(0, 32'h1001_0004, 0, 32'hDEAD_BEEF, 0, 0);   // updated cached word
        access(0, 32'h1001_0100, 0, 32'hA500_0040, 5, 1);   // conflict evicts line 0
        access(0, 32'h1001_0000, 0, 32'hA500_0000, 5, 1);   // misses again
`ifdef CACHE_STATS_EN
        chk("miss_cnt", miss_cnt, 3);
        chk("hit_cnt",  hit_cnt, 2);
`endif
        access(0, 32'h1001_0004, 0, 32'hDEAD_BEEF, 0, 0);   // RAM got the write too

        // Reset after the second refill word has been captured.
        ra_q.push_back(32'h1001_0100);
        ra_q.push_back(32'h1001_0104);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0100;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_ce_n", mem_ce_n, 1);
        chk("abort_oe_n", mem_oe_n, 1);
        chk("abort_we_n", mem_we_n, 1);
        chk("abort_addr", mem_addr, 32'h0);
        chk("abort_hold", cpu_hold, 0);
`ifdef CACHE_STATS_EN
        chk("abort_miss_cnt", miss_cnt, 0);
`endif
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        access(0, 32'h1001_0100, 0, 32'hA500_0040, 5, 1);   // partial line stayed invalid
        access(0, 32'h1001_0000, 0, 32'hA500_0000, 5, 1);   // full 4-word refill

        // No-allocate write to an uncached line, then read it back from RAM.
        access(1, 32'h1001_0200, 32'h1234_5678, 0, 1, 0);
        access(0, 32'h1001_0200, 0, 32'h1234_5678, 5, 1);
`ifdef CACHE_STATS_EN
        chk("final_miss_cnt", miss_cnt, 3);
        chk("final_hit_cnt",  hit_cnt, 0);
`endif

        repeat (2) @(posedge clk);
        chk("rd_q_left", rd_q.size(), 0);
        chk("ra_q_left", ra_q.size(), 0);
        chk("wr_q_left", wr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The module SHALL have parameter LINES, default 16, giving the number of direct-mapped lines; it SHALL be a power of two, at least 2.
REQ-002 The module SHALL have parameter LINE_WORDS, default 4, giving the 32-bit words per line; it is fixed at 4.
REQ-003 The ports SHALL be, one per line:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address, word-aligned.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid when cpu_req=1, cpu_we=0 and cpu_hold=0.
- cpu_hold  out  1  stall; the request completes in the cycle where cpu_req=1 and cpu_hold=0.
- mem_addr  out  32  RAM address.
- mem_data  inout  32  RAM data bus.
- mem_ce_n  out  1  RAM chip enable, active low.
- mem_we_n  out  1  RAM write enable, active low.
- mem_oe_n  out  1  RAM output enable, active low.
- mem_bw  out  1  RAM byte/word select; the module drives 1 (word) permanently.
- hit_cnt  out  32  read-hit counter; present only with CACHE_STATS_EN.
- miss_cnt  out  32  read-miss counter; present only with CACHE_STATS_EN.

Function
REQ-004 The cache SHALL split the address as: offset = addr[3:2], index = addr[4+log2(LINES)-1:4], tag = the remaining upper bits.
REQ-005 Each line SHALL hold a valid bit, a tag and 4 data words.
REQ-006 The FSM SHALL have three states: IDLE, REFILL and WRITE.
REQ-007 Hit SHALL be computed combinationally in IDLE as cpu_req & valid[index] & (tag match).
REQ-008 On a read hit in IDLE, cpu_hold SHALL be 0 and cpu_rdata SHALL equal the line word in that same cycle (zero-wait).
REQ-009 On a read miss in IDLE, cpu_hold SHALL be 1 and the FSM SHALL go to REFILL with the word counter = 0 and valid[index] cleared.
REQ-010 In REFILL, each cycle SHALL drive:
- mem_ce_n=0, mem_oe_n=0, mem_we_n=1;
- mem_addr = {tag, index, counter, 2'b00};
- mem_data sampled at the closing rising edge into word[counter];
- counter incremented.
REQ-011 After word 3, REFILL SHALL set valid[index], write the tag and return to IDLE; the request then hits, giving a total read-miss latency of 5 held cycles.
REQ-012 On a write in IDLE, cpu_hold SHALL be 1 and the FSM SHALL go to WRITE.
REQ-013 WRITE SHALL be write-through and no-allocate. In its single cycle it SHALL:
- drive mem_ce_n=0, mem_we_n=0, mem_oe_n=1, mem_addr=cpu_addr, mem_data=cpu_wdata;
- drive cpu_hold=0;
- update the cached word if it is a hit;
- return to IDLE.
REQ-014 mem_data SHALL be high-Z in every cycle except WRITE.
REQ-015 In IDLE with no request, the module SHALL drive mem_ce_n=mem_we_n=mem_oe_n=1 and cpu_hold=0.
REQ-016 The CPU holds its request stable until completion; deassertion of cpu_req during REFILL or WRITE SHALL be ignored and the operation SHALL finish.

Reset
REQ-017 While reset=1, asynchronously:
- all valid bits SHALL clear;
- the FSM SHALL go to IDLE and the counter SHALL go to 0;
- mem_ce_n, mem_we_n and mem_oe_n SHALL be 1, mem_data SHALL be high-Z and mem_addr SHALL be 0;
- cpu_hold SHALL be 0;
- any counters SHALL be 0.
REQ-018 Reset during REFILL SHALL leave the partially filled line invalid.

Configuration
REQ-019 With macro CACHE_STATS_EN defined:
- miss_cnt SHALL increment on each IDLE-to-REFILL transition;
- hit_cnt SHALL increment on each completed read hit in IDLE not immediately preceded by REFILL;
- both counters SHALL wrap modulo 2^32.
REQ-020 Without CACHE_STATS_EN, the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-021 Package cache_pkg SHALL hold the state enum (IDLE/REFILL/WRITE), the line struct (valid, tag, words) and the offset-width constant.
REQ-022 The tag/data storage SHALL be a sub-module, cache_array: a LINES-entry store with one word-write port, line-valid and tag update, and combinational read.

Verification
REQ-023 The bench SHALL use the existing ram model (text.bin loaded) downstream and cover:
- Reset, then read 0x10010000 -> cpu_hold high 5 cycles; mem_addr 0x10010000, 0x10010004, 0x10010008, 0x1001000C with oe_n/ce_n low; cpu_rdata = RAM word 0.
- Read 0x10010008 next -> hold 0 in the same cycle; no mem_ce_n activity; RAM word 2 returned.
- Write 0x10010004 = 0xDEADBEEF -> one WRITE cycle with we_n=0 and the bus driven; a later read of 0x10010004 hits and returns 0xDEADBEEF.
- Read 0x10010100 (same index, different tag) -> refill evicts the line; a re-read of 0x10010000 misses again; miss_cnt=3, hit_cnt=2 (stats build).
- Reset asserted after the 2nd refill word -> bus released and ce_n=1 immediately; a re-read of 0x10010000 does a full 4-word refill.
- Write to an uncached address 0x10010200 -> RAM updated; a subsequent read of it misses (no-allocate).
